// File: rtl/watch_pkg.sv
// watch_pkg: set-mode states, display field codes and field limits shared by the watch core
package watch_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} state_t;
  localparam logic [1:0] FIELD_RUN = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN = 2'b10;
  localparam logic [1:0] FIELD_SEC = 2'b11;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HOUR_MAX = 23;
  function automatic state_t next_state(state_t s);
    return s == RUN ? SET_HOUR : s == SET_HOUR ? SET_MIN : s == SET_MIN ? SET_SEC : RUN;
  endfunction
  function automatic logic [1:0] field_of(state_t s);
    return s == SET_HOUR ? FIELD_HOUR : s == SET_MIN ? FIELD_MIN : s == SET_SEC ? FIELD_SEC : FIELD_RUN;
  endfunction
endpackage

// File: rtl/watch_if.sv
// watch_if: debounced button levels in, time-of-day display fields out
//  master: drives i_mode/i_clear/i_up/i_down/i_h12, reads o_msec/o_sec/o_min/o_hour/o_pm/o_field
//  slave : the watch core
interface watch_if #(parameter int TICK_HZ = 100);
  localparam int MW = $clog2(TICK_HZ);
  logic i_mode, i_clear, i_up, i_down, i_h12;
  logic [MW-1:0] o_msec;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic o_pm;
  logic [1:0] o_field;
  modport master(output i_mode, i_clear, i_up, i_down, i_h12,
                 input o_msec, o_sec, o_min, o_hour, o_pm, o_field);
  modport slave(input i_mode, i_clear, i_up, i_down, i_h12,
                output o_msec, o_sec, o_min, o_hour, o_pm, o_field);
endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: modular 0..MAX counter with clear > inc > dec priority and carry on inc at MAX
//  clk, rst_n   clock, async active-low reset (loads INIT)
//  i_inc/i_dec  step up/down with wrap; i_clr forces 0
//  o_value      registered count; o_carry combinational, high when i_inc wraps MAX->0
module wrap_counter #(
  parameter int MAX = 59,
  parameter int W = 6,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_clr,
  output logic [W-1:0] o_value,
  output logic         o_carry
);
  logic [W-1:0] r_value;
  assign o_value = r_value;
  assign o_carry = i_inc && r_value == W'(MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_value <= W'(INIT);
    else if (i_clr) r_value <= '0;
    else if (i_inc) r_value <= o_carry ? '0 : r_value + 1'b1;
    else if (i_dec) r_value <= r_value == '0 ? W'(MAX) : r_value - 1'b1;
endmodule

// File: rtl/watch_core_p.sv
// watch_core_p: time-of-day watch with tick divider, msec/sec/min/hour cascade, set-mode editing and 12/24h display
//  clk, rst_n  clock, async active-low reset
//  bus         watch_if.slave: button levels in, msec/sec/min/hour/pm/field out
module watch_core_p import watch_pkg::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int INIT_HOUR = 12,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input logic clk,
  input logic rst_n,
  watch_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int MW = $clog2(TICK_HZ);
  localparam int RW = $clog2(REPEAT_DLY + REPEAT_PER + 1);
  state_t r_state, w_state_nx;
  logic r_mode, r_clear, r_up, r_down;
  logic [DW-1:0] r_div;
  logic [RW-1:0] r_rep, w_rep_nx;
  logic w_mode_e, w_clear_e, w_up_e, w_down_e, w_one, w_tick, w_run, w_exit, w_edit;
  logic w_clr_run, w_clr_set, w_rep_wrap, w_rep_step, w_step_up, w_step_dn;
  logic w_ms_carry, w_sec_carry, w_min_carry, w_hour_carry_unused;
  logic [4:0] w_hour;
  assign w_mode_e = bus.i_mode & ~r_mode;
  assign w_clear_e = bus.i_clear & ~r_clear;
  assign w_up_e = bus.i_up & ~r_up;
  assign w_down_e = bus.i_down & ~r_down;
  assign w_one = bus.i_up ^ bus.i_down;
  assign w_tick = r_div == DW'(DIV - 1);
  assign w_run = r_state == RUN;
  assign w_exit = r_state == SET_SEC && w_mode_e;
  // a mode edge swallows any edit requested in the same cycle
  assign w_edit = ~w_run & ~w_mode_e;
  assign w_clr_run = w_run & w_clear_e & ~w_mode_e;
  assign w_clr_set = w_edit & w_clear_e;
  // repeat timer fires at DLY, then folds back to DLY every PER ticks
  assign w_rep_nx = r_rep + 1'b1;
  assign w_rep_wrap = w_rep_nx == RW'(REPEAT_DLY + REPEAT_PER);
  assign w_rep_step = w_edit & w_one & w_tick & (w_rep_nx == RW'(REPEAT_DLY) | w_rep_wrap);
  assign w_step_up = w_edit & ~w_clear_e & ~bus.i_down & (w_up_e | (w_rep_step & bus.i_up));
  assign w_step_dn = w_edit & ~w_clear_e & ~bus.i_up & (w_down_e | (w_rep_step & bus.i_down));
  always_comb w_state_nx = w_mode_e ? next_state(r_state) : r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RUN;
      {r_mode, r_clear, r_up, r_down} <= '0;
      r_div <= '0;
      r_rep <= '0;
    end else begin
      r_state <= w_state_nx;
      {r_mode, r_clear, r_up, r_down} <= {bus.i_mode, bus.i_clear, bus.i_up, bus.i_down};
      r_div <= (w_tick | w_clr_run | w_exit) ? '0 : r_div + 1'b1;
      r_rep <= (w_run | w_mode_e | ~w_one) ? '0 : w_tick ? (w_rep_wrap ? RW'(REPEAT_DLY) : w_rep_nx) : r_rep;
    end
  wrap_counter #(.MAX(TICK_HZ - 1), .W(MW)) u_msec (
    .clk(clk), .rst_n(rst_n), .i_inc(w_run & w_tick & ~w_clr_run), .i_dec(1'b0),
    .i_clr(w_clr_run | w_exit), .o_value(bus.o_msec), .o_carry(w_ms_carry));
  wrap_counter #(.MAX(SEC_MAX), .W(6)) u_sec (
    .clk(clk), .rst_n(rst_n), .i_inc(w_ms_carry | (r_state == SET_SEC & w_step_up)),
    .i_dec(r_state == SET_SEC & w_step_dn), .i_clr(w_clr_run | (r_state == SET_SEC & w_clr_set)),
    .o_value(bus.o_sec), .o_carry(w_sec_carry));
  // edit steps raise carry at the field max, so carries only propagate while running
  wrap_counter #(.MAX(MIN_MAX), .W(6)) u_min (
    .clk(clk), .rst_n(rst_n), .i_inc((w_run & w_sec_carry) | (r_state == SET_MIN & w_step_up)),
    .i_dec(r_state == SET_MIN & w_step_dn), .i_clr(r_state == SET_MIN & w_clr_set),
    .o_value(bus.o_min), .o_carry(w_min_carry));
  wrap_counter #(.MAX(HOUR_MAX), .W(5), .INIT(INIT_HOUR)) u_hour (
    .clk(clk), .rst_n(rst_n), .i_inc((w_run & w_min_carry) | (r_state == SET_HOUR & w_step_up)),
    .i_dec(r_state == SET_HOUR & w_step_dn), .i_clr(r_state == SET_HOUR & w_clr_set),
    .o_value(w_hour), .o_carry(w_hour_carry_unused));
  assign bus.o_pm = w_hour >= 5'd12;
  assign bus.o_hour = !bus.i_h12 ? w_hour : w_hour == 5'd0 ? 5'd12 : w_hour > 5'd12 ? w_hour - 5'd12 : w_hour;
  assign bus.o_field = field_of(r_state);
endmodule

// File: tb/tb_watch_core_p.sv
// tb_watch_core_p: randomized button stimulus against a time-in-centiseconds reference model, queue scoreboard
module tb_watch_core_p;
  localparam int DIVN = 10;
  localparam int DLY = 5;
  localparam int PER = 2;
  localparam int INIT_HOUR = 12;
  localparam int DAY = 24 * 3600 * 100;
  typedef struct packed {int field; int ms; int sec; int min; int hour; int pm;} exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic h12 = 0;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int m_st, m_t, m_div, m_held;
  logic p_mode, p_clear, p_up, p_down;
  always #5 clk = ~clk;
  watch_if #(.TICK_HZ(100)) bus();
  watch_core_p #(.CLK_HZ(1000), .TICK_HZ(100), .INIT_HOUR(INIT_HOUR), .REPEAT_DLY(DLY), .REPEAT_PER(PER))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic model_reset();
    m_st = 0;
    m_t = INIT_HOUR * 360000;
    m_div = 0;
    m_held = 0;
    {p_mode, p_clear, p_up, p_down} = '0;
  endtask
  function automatic exp_t expect_now(input logic fmt12);
    exp_t e;
    int h;
    h = m_t / 360000;
    e.field = m_st;
    e.ms = m_t % 100;
    e.sec = (m_t / 100) % 60;
    e.min = (m_t / 6000) % 60;
    e.pm = h >= 12 ? 1 : 0;
    e.hour = !fmt12 ? h : (h % 12 == 0 ? 12 : h % 12);
    return e;
  endfunction
  task automatic model_step(input logic [3:0] b);
    logic mo, cl, up, dn, me, ce, ue, de, one, tick, rstep;
    int h, mi, s, cs, d;
    {mo, cl, up, dn} = b;
    me = mo & ~p_mode;
    ce = cl & ~p_clear;
    ue = up & ~p_up;
    de = dn & ~p_down;
    one = up != dn;
    tick = m_div == DIVN - 1;
    m_div = tick ? 0 : m_div + 1;
    if (m_st == 0) begin
      m_held = 0;
      if (ce && !me) begin
        m_t -= m_t % 6000;
        m_div = 0;
      end else if (tick) m_t = (m_t + 1) % DAY;
      if (me) m_st = 1;
    end else if (me) begin
      m_held = 0;
      if (m_st == 3) begin
        m_st = 0;
        m_t -= m_t % 100;
        m_div = 0;
      end else m_st++;
    end else begin
      if (!one) m_held = 0;
      else if (tick) m_held++;
      rstep = one && tick && (m_held == DLY || (m_held > DLY && (m_held - DLY) % PER == 0));
      h = m_t / 360000;
      mi = (m_t / 6000) % 60;
      s = (m_t / 100) % 60;
      cs = m_t % 100;
      d = ce ? 0 : ((ue && !dn) || (rstep && up)) ? 1 : ((de && !up) || (rstep && dn)) ? -1 : 0;
      if (m_st == 1) h = ce ? 0 : (h + d + 24) % 24;
      if (m_st == 2) mi = ce ? 0 : (mi + d + 60) % 60;
      if (m_st == 3) s = ce ? 0 : (s + d + 60) % 60;
      m_t = ((h * 60 + mi) * 60 + s) * 100 + cs;
    end
    {p_mode, p_clear, p_up, p_down} = b;
  endtask
  task automatic cyc(input logic [3:0] b);
    {bus.i_mode, bus.i_clear, bus.i_up, bus.i_down} = b;
    bus.i_h12 = h12;
    model_step(b);
    q.push_back(expect_now(h12));
    @(negedge clk);
  endtask
  task automatic hold(input logic [3:0] b, input int n);
    repeat (n) cyc(b);
    cyc(4'b0000);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_field"}, int'(bus.o_field), 0);
    chk({tag, "_msec"}, int'(bus.o_msec), 0);
    chk({tag, "_sec"}, int'(bus.o_sec), 0);
    chk({tag, "_min"}, int'(bus.o_min), 0);
    chk({tag, "_hour"}, int'(bus.o_hour), INIT_HOUR);
    chk({tag, "_pm"}, int'(bus.o_pm), 1);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("field", int'(bus.o_field), e.field);
        chk("msec", int'(bus.o_msec), e.ms);
        chk("sec", int'(bus.o_sec), e.sec);
        chk("min", int'(bus.o_min), e.min);
        chk("hour", int'(bus.o_hour), e.hour);
        chk("pm", int'(bus.o_pm), e.pm);
      end
    end
  end
  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin : stim
    {bus.i_mode, bus.i_clear, bus.i_up, bus.i_down, bus.i_h12} = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1;
    repeat (1000) cyc(4'b0000);
    hold(4'b1000, 1);
    repeat (13) hold(4'b0001, 1);
    hold(4'b1000, 1);
    hold(4'b0001, 1);
    hold(4'b1000, 1);
    hold(4'b0001, 1);
    hold(4'b1000, 1);
    h12 = 1;
    repeat (1010) cyc(4'b0000);
    hold(4'b1000, 1);
    hold(4'b0001, 1);
    hold(4'b0010, 1);
    hold(4'b0001, 1);
    h12 = 0;
    hold(4'b1000, 1);
    hold(4'b1000, 1);
    hold(4'b0010, 115);
    hold(4'b0011, 60);
    hold(4'b0100, 1);
    hold(4'b1000, 1);
    repeat (300) cyc(4'b0000);
    hold(4'b0100, 1);
    repeat (50) cyc(4'b0000);
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0: repeat ($urandom_range(1, 40)) cyc(4'b0000);
        1: hold(4'b1000, 1);
        2: hold(4'b0100, 1);
        3: hold(4'b0010, 1);
        4: hold(4'b0001, 1);
        5: hold(4'b0010, $urandom_range(5, 80));
        6: hold(4'b0001, $urandom_range(5, 80));
        7: hold(4'b0011, $urandom_range(3, 30));
        8: hold(4'($urandom_range(0, 15)), 1);
        default: begin
          h12 = ~h12;
          repeat ($urandom_range(1, 5)) cyc(4'b0000);
        end
      endcase
    end
    for (int i = 0; i < 4 && m_st != 0; i++) hold(4'b1000, 1);
    hold(4'b1000, 1);
    hold(4'b1000, 1);
    hold(4'b0010, 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1 check_reset("async");
    @(negedge clk);
    {bus.i_mode, bus.i_clear, bus.i_up, bus.i_down} = '0;
    model_reset();
    rst_n = 1;
    repeat (50) cyc(4'b0000);
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
